tt_um_tinymoa_ihp26a: RTL and testbench

TT_UM_TINYMOA_IHP26A -- requirements
Module: tt_um_tinymoa_ihp26a

---
 rtl/tt_um_tinymoa_ihp26a.sv | 201 ++++++++++++++++++++
 tb/tb_tt_um_tinymoa_ihp26a.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_tinymoa_ihp26a.sv
// Bit-serial 8x8 dot-product engine driven by strobed byte commands.
// Define TINYDCIM_SIGNED_EN for two's-complement W/X; default build is unsigned.
module tt_um_tinymoa_ihp26a (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [2:0] OP_SET_ADDR = 3'd1;
   localparam logic [2:0] OP_WRITE_W  = 3'd2;
   localparam logic [2:0] OP_WRITE_X  = 3'd3;
   localparam logic [2:0] OP_START    = 3'd4;
   localparam logic [2:0] OP_READ_SEL = 3'd5;
   localparam logic [2:0] OP_CLEAR    = 3'd6;

   logic [7:0]  w_q [0:7];
   logic [7:0]  w_d [0:7];
   logic [7:0]  x_q [0:7];
   logic [7:0]  x_d [0:7];
   logic [2:0]  ptr_q, ptr_d;
   logic [1:0]  sel_q, sel_d;
   logic [23:0] r_q, r_d;
   logic [23:0] acc_q, acc_d;
   logic [2:0]  k_q, k_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        strb_q, strb_d;
   logic [7:0]  uo_q, uio_q;

   logic        cmd_s;
   logic [23:0] plane_s;
   logic [23:0] term_s;
   logic [23:0] acc_next_s;
   logic        unused_s;

   function automatic logic [23:0] ext_w(input logic [7:0] w);
`ifdef TINYDCIM_SIGNED_EN
      ext_w = {{16{w[7]}}, w};
`else
      ext_w = {16'h0000, w};
`endif
   endfunction

   function automatic logic [7:0] sel_byte(input logic [1:0] sel, input logic [23:0] r,
                                           input logic [2:0] ptr);
      case (sel)
         2'd0:    sel_byte = r[7:0];
         2'd1:    sel_byte = r[15:8];
         2'd2:    sel_byte = r[23:16];
         default: sel_byte = {5'b00000, ptr};
      endcase
   endfunction

   assign cmd_s    = ena & uio_in[3] & ~strb_q;
   assign unused_s = &{1'b0, uio_in[7:4]};

   // Partial product of bit-plane k, shifted into place and folded into the accumulator.
   always_comb begin
      plane_s = 24'h000000;
      for (int i = 0; i < 8; i++) begin
         if (x_q[i][k_q]) begin
            plane_s = plane_s + ext_w(w_q[i]);
         end else begin
            plane_s = plane_s;
         end
      end
      term_s = plane_s << k_q;
`ifdef TINYDCIM_SIGNED_EN
      acc_next_s = (k_q == 3'd7) ? (acc_q - term_s) : (acc_q + term_s);
`else
      acc_next_s = acc_q + term_s;
`endif
   end

   // Next-state: compute step first, then the command, so CLEAR can abort a running job.
   always_comb begin
      w_d    = w_q;
      x_d    = x_q;
      ptr_d  = ptr_q;
      sel_d  = sel_q;
      r_d    = r_q;
      acc_d  = acc_q;
      k_d    = k_q;
      busy_d = busy_q;
      done_d = done_q;
      strb_d = strb_q;
      if (ena) begin
         strb_d = uio_in[3];
         if (busy_q) begin
            if (k_q == 3'd7) begin
               r_d    = acc_next_s;
               acc_d  = 24'h000000;
               k_d    = 3'd0;
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               acc_d = acc_next_s;
               k_d   = k_q + 3'd1;
            end
         end else begin
            acc_d = acc_q;
         end
         if (cmd_s) begin
            case (uio_in[2:0])
               OP_SET_ADDR: begin
                  if (!busy_q) ptr_d = ui_in[2:0];
                  else         ptr_d = ptr_q;
               end
               OP_WRITE_W: begin
                  if (!busy_q) begin
                     w_d[ptr_q] = ui_in;
                     ptr_d      = ptr_q + 3'd1;
                  end else begin
                     ptr_d = ptr_q;
                  end
               end
               OP_WRITE_X: begin
                  if (!busy_q) begin
                     x_d[ptr_q] = ui_in;
                     ptr_d      = ptr_q + 3'd1;
                  end else begin
                     ptr_d = ptr_q;
                  end
               end
               OP_START: begin
                  if (!busy_q) begin
                     busy_d = 1'b1;
                     done_d = 1'b0;
                     acc_d  = 24'h000000;
                     k_d    = 3'd0;
                  end else begin
                     busy_d = busy_d;
                  end
               end
               OP_READ_SEL: sel_d = ui_in[1:0];
               OP_CLEAR: begin
                  for (int i = 0; i < 8; i++) begin
                     w_d[i] = 8'h00;
                     x_d[i] = 8'h00;
                  end
                  r_d    = 24'h000000;
                  ptr_d  = 3'd0;
                  sel_d  = 2'd0;
                  acc_d  = 24'h000000;
                  k_d    = 3'd0;
                  busy_d = 1'b0;
                  done_d = 1'b0;
               end
               default: ptr_d = ptr_d;
            endcase
         end else begin
            ptr_d = ptr_d;
         end
      end else begin
         strb_d = strb_q;
      end
   end

   // State and output registers; outputs are built from next-state so they track state exactly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            w_q[i] <= 8'h00;
            x_q[i] <= 8'h00;
         end
         ptr_q  <= 3'd0;
         sel_q  <= 2'd0;
         r_q    <= 24'h000000;
         acc_q  <= 24'h000000;
         k_q    <= 3'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         strb_q <= 1'b0;
         uo_q   <= 8'h00;
         uio_q  <= 8'h80;
      end else begin
         w_q    <= w_d;
         x_q    <= x_d;
         ptr_q  <= ptr_d;
         sel_q  <= sel_d;
         r_q    <= r_d;
         acc_q  <= acc_d;
         k_q    <= k_d;
         busy_q <= busy_d;
         done_q <= done_d;
         strb_q <= strb_d;
         uo_q   <= sel_byte(sel_d, r_d, ptr_d);
         uio_q  <= {(r_d == 24'h000000), r_d[23], done_d, busy_d, 4'h0};
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = uio_q;
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_tinymoa_ihp26a.sv
// Directed bench for tt_um_tinymoa_ihp26a: command table plus hand-written corner sequences.
module tb_tt_um_tinymoa_ihp26a;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] data;
      int         wait_n;
      logic [7:0] exp_uo;
      logic [7:0] exp_uio;
   } vec_t;

   vec_t vecs[$];

   tt_um_tinymoa_ihp26a dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One command: strobe high for one edge, then low for one edge; returns on the negedge after execution.
   task automatic cmd(input logic [2:0] op, input logic [7:0] d);
      @(negedge clk);
      ui_in  = d;
      uio_in = {4'h0, 1'b1, op};
      @(negedge clk);
      uio_in = {4'h0, 1'b0, op};
   endtask

   task automatic start_and_wait(input string name);
      int n;
      cmd(3'd4, 8'h00);
      n = 0;
      while (uio_out[5] !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: done never set, got %h expected done bit", name, uio_out);
      end
   endtask

   task automatic fill_all(input logic [7:0] wv, input logic [7:0] xv);
      cmd(3'd1, 8'h00);
      for (int i = 0; i < 8; i++) cmd(3'd2, wv);
      cmd(3'd1, 8'h00);
      for (int i = 0; i < 8; i++) cmd(3'd3, xv);
   endtask

   task automatic check_r(input string name, input logic [23:0] exp_r, input logic [7:0] exp_uio);
      cmd(3'd5, 8'h00);
      check({name, " b0"}, uo_out, exp_r[7:0]);
      cmd(3'd5, 8'h01);
      check({name, " b1"}, uo_out, exp_r[15:8]);
      cmd(3'd5, 8'h02);
      check({name, " b2"}, uo_out, exp_r[23:16]);
      check({name, " status"}, uio_out, exp_uio);
      cmd(3'd5, 8'h00);
   endtask

   initial begin
      int n;
      logic [23:0] exp_a, exp_b;
      logic [7:0]  uio_a, uio_b;

      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset uo_out", uo_out, 8'h00);
      check("reset uio_out", uio_out, 8'h80);
      check("reset uio_oe", uio_oe, 8'hF0);
      rst_n = 1'b1;

      // Dot product W=1, X=1..8 -> 36
      vecs.push_back('{3'd1, 8'h00, 0, 8'h00, 8'h80});
      vecs.push_back('{3'd5, 8'h03, 0, 8'h00, 8'h80});
      for (int i = 0; i < 8; i++) begin
         logic [7:0] p;
         p = 8'(i + 1) & 8'h07;
         vecs.push_back('{3'd2, 8'h01, 0, p, 8'h80});
      end
      vecs.push_back('{3'd1, 8'h00, 0, 8'h00, 8'h80});
      for (int i = 0; i < 8; i++) begin
         logic [7:0] p;
         p = 8'(i + 1) & 8'h07;
         vecs.push_back('{3'd3, 8'(i + 1), 0, p, 8'h80});
      end
      vecs.push_back('{3'd5, 8'h00, 0, 8'h00, 8'h80});
      vecs.push_back('{3'd4, 8'h00, 0, 8'h00, 8'h90});
      vecs.push_back('{3'd0, 8'h00, 5, 8'h00, 8'h90});
      vecs.push_back('{3'd0, 8'h00, 1, 8'h24, 8'h20});
      vecs.push_back('{3'd5, 8'h01, 0, 8'h00, 8'h20});
      vecs.push_back('{3'd5, 8'h02, 0, 8'h00, 8'h20});
      vecs.push_back('{3'd5, 8'h00, 0, 8'h24, 8'h20});
      vecs.push_back('{3'd7, 8'h5A, 0, 8'h24, 8'h20});
      vecs.push_back('{3'd0, 8'h00, 4, 8'h24, 8'h20});

      for (int i = 0; i < vecs.size(); i++) begin
         cmd(vecs[i].op, vecs[i].data);
         repeat (vecs[i].wait_n) @(negedge clk);
         check($sformatf("vec%0d uo_out", i), uo_out, vecs[i].exp_uo);
         check($sformatf("vec%0d uio_out", i), uio_out, vecs[i].exp_uio);
      end

      // Single-product and all-ones cases, signedness selected by build
`ifdef TINYDCIM_SIGNED_EN
      exp_a = 24'hFFC080; uio_a = 8'h60;
      exp_b = 24'h000008; uio_b = 8'h20;
`else
      exp_a = 24'h003F80; uio_a = 8'h20;
      exp_b = 24'h07F008; uio_b = 8'h20;
`endif
      cmd(3'd6, 8'h00);
      check("clear status", uio_out, 8'h80);
      cmd(3'd1, 8'h00);
      cmd(3'd2, 8'h80);
      cmd(3'd1, 8'h00);
      cmd(3'd3, 8'h7F);
      start_and_wait("w80x7f");
      check_r("w80x7f", exp_a, uio_a);

      cmd(3'd6, 8'h00);
      fill_all(8'hFF, 8'hFF);
      start_and_wait("allff");
      check_r("allff", exp_b, uio_b);

      // Pointer wrap 7 -> 0, then prove W[7] and W[0] were written via a dot product
      cmd(3'd6, 8'h00);
      cmd(3'd1, 8'h07);
      cmd(3'd2, 8'h02);
      cmd(3'd2, 8'h03);
      cmd(3'd5, 8'h03);
      check("wrap ptr", uo_out, 8'h01);
      cmd(3'd1, 8'h00);
      for (int i = 0; i < 8; i++) cmd(3'd3, 8'h01);
      start_and_wait("wrap");
      check_r("wrap", 24'h000005, 8'h20);

      // START while busy ignored: busy lasts 8 cycles from the first START
      cmd(3'd4, 8'h00);
      cmd(3'd4, 8'h00);
      n = 0;
      while (uio_out[4] === 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (n != 6) begin
         n_fail++;
         $display("FAIL busy length: got %0d extra cycles expected 6", n);
      end
      check("busy done status", uio_out, 8'h20);
      check("busy result", uo_out, 8'h05);

      // CLEAR on the 4th cycle of a computation aborts it
      cmd(3'd4, 8'h00);
      @(negedge clk);
      cmd(3'd6, 8'h00);
      check("clear abort status", uio_out, 8'h80);
      check("clear abort uo", uo_out, 8'h00);
      repeat (12) @(negedge clk);
      check("clear abort later", uio_out, 8'h80);

      // ena=0 ignores commands
      cmd(3'd1, 8'h00);
      cmd(3'd2, 8'h01);
      cmd(3'd1, 8'h00);
      cmd(3'd3, 8'h01);
      start_and_wait("one");
      check("one result", uo_out, 8'h01);
      ena = 1'b0;
      cmd(3'd5, 8'h03);
      cmd(3'd6, 8'h00);
      check("ena0 uo", uo_out, 8'h01);
      check("ena0 uio", uio_out, 8'h20);
      ena = 1'b1;

      // Reset during computation leaves R = 0
      cmd(3'd4, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset uo", uo_out, 8'h00);
      check("midreset uio", uio_out, 8'h80);
      repeat (12) @(negedge clk);
      check("midreset later", uio_out, 8'h80);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
